instr_fetch_unit: RTL and testbench
===================================

Name: instr_fetch_unit

Overview:
- Instruction fetch stage sitting directly upstream of the CPU control decoder.
- Generates sequential PCs and issues word requests to instruction memory using a req/gnt plus rvalid protocol.
- Buffers returned words with their PCs in a small FIFO and presents them to the decoder through a valid/ready handshake.
- Handles branch/jump redirects by flushing the FIFO and discarding any stale in-flight response.

Parameters:
- XLEN, 32, width of the PC, address and instruction words.
- RESET_PC, 32'h0000_0000, fetch address after reset.
- FIFO_DEPTH, 2, number of fetched-instruction entries; must be a power of 2 and at least 2.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset; asynchronous, active-high.
- imem_req  out  1  request valid to instruction memory.
- imem_addr  out  XLEN  word-aligned fetch address; bits [1:0] are always 0.
- imem_gnt  in  1  memory accepts the request this cycle.
- imem_rvalid  in  1  read data valid; returns for the single outstanding request, at least 1 cycle after gnt.
- imem_rdata  in  XLEN  returned instruction word.
- redirect_valid  in  1  taken branch or jump from execute.
- redirect_target  in  XLEN  new PC; bits [1:0] are ignored and forced to 0.
- instruction  out  XLEN  instruction at the FIFO head, to the decoder.
- instr_pc  out  XLEN  PC of the head instruction.
- instr_valid  out  1  FIFO not empty.
- instr_ready  in  1  decoder consumes the head this cycle.

Behaviour:
- Reset (async, instantaneous):
  - fetch_pc = RESET_PC; FIFO empty; outstanding = 0; discard = 0.
  - imem_req = 0, instr_valid = 0.
  - instruction = 32'h00000013 (NOP), instr_pc = 0.
- Reset mid-transaction: a later imem_rvalid for the aborted request is ignored, because outstanding = 0.
- Request rule:
  - imem_req = !rst && !outstanding && !redirect_valid && (count < FIFO_DEPTH).
  - imem_addr = fetch_pc.
  - Only one request is ever outstanding.
- Grant: when imem_req && imem_gnt, set outstanding = 1, record req_pc = fetch_pc, and set fetch_pc += 4 (wraps modulo 2^XLEN).
- Response: on imem_rvalid with outstanding = 1, clear outstanding.
  - If discard = 0, push {imem_rdata, req_pc}.
  - If discard = 1, drop the word and clear discard.
  - imem_rvalid while outstanding = 0 is ignored.
- Space reservation: a request is issued only when count < FIFO_DEPTH, so a push never hits a full FIFO.
- Push and pop in the same cycle: count stays the same; order is preserved.
- Output:
  - instr_valid = (count != 0).
  - instruction and instr_pc show the head combinationally from FIFO storage.
  - When empty, instruction = NOP and instr_pc holds its last value.
- Pop: on instr_valid && instr_ready && !redirect_valid.
- Redirect (highest priority):
  - In the cycle redirect_valid = 1: fetch_pc <= {redirect_target[XLEN-1:2], 2'b00}; FIFO flushed (count = 0); no pop.
  - If outstanding = 1 and imem_rvalid = 0 that cycle, set discard = 1.
  - If imem_rvalid = 1 that same cycle, the word is dropped and outstanding clears.
  - imem_req is low during the redirect cycle.
  - The first request to the target is issued the next cycle.
- Back-to-back redirects: the last one wins; discard stays 1 until the single stale response returns.
- Latency:
  - Redirect at cycle N gives imem_req to the target at N+1.
  - With gnt at N+1 and rvalid at N+2, instr_valid rises at N+3.
  - Sustained throughput is one instruction per 2 cycles with 1-cycle memory.
- State machine, derived from outstanding/discard:
  - IDLE: no request possible (FIFO full or redirect cycle).
  - REQ: imem_req high, waiting for gnt.
  - WAIT: outstanding, waiting for rvalid.
  - WAIT_DISCARD: outstanding with discard = 1.
  - Transitions follow the rules above; reset goes to REQ-eligible with outstanding = 0.

Test Plan:
- Reset release, memory returning 32'h00310233 at 0x0 and 32'h00311333 at 0x4 with 1-cycle latency, instr_ready = 1 -> imem_addr 0x0 then 0x4; outputs are (0x00310233, pc 0x0) then (0x00311333, pc 0x4); imem_req is never high while outstanding.
- instr_ready = 0 for 10 cycles -> exactly FIFO_DEPTH = 2 words are fetched (0x0, 0x4), then imem_req stays low; raising instr_ready resumes fetch at 0x8 with no loss or duplication.
- Redirect to 0x0000_0102 while a fetch of 0x8 is outstanding, with rvalid 2 cycles later carrying 32'h00401263 -> that word is discarded, the FIFO is emptied, the next imem_addr is 0x100, and the first instr_pc after that is 0x100.
- Redirect in the same cycle as imem_rvalid, then a second redirect to 0x200 one cycle later -> no stale instruction appears; the first valid instr_pc is 0x200.
- Async rst asserted between gnt and rvalid, with a stale rvalid arriving after reset -> instr_valid stays 0 and the first request after release is to RESET_PC = 0x0.
- Start fetch_pc at 0xFFFF_FFFC (via redirect) -> the next request wraps to 0x0000_0000.

Source files
------------

// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: issues one word request at a time, buffers returned words with their PCs,
// and hands them to the decoder. A redirect flushes the buffer and discards any stale in-flight word.
module instr_fetch_unit #(
    parameter int                XLEN       = 32,
    parameter logic [XLEN-1:0]   RESET_PC   = '0,
    parameter int                FIFO_DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_gnt,
    input  logic            imem_rvalid,
    input  logic [XLEN-1:0] imem_rdata,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_target,
    output logic [XLEN-1:0] instruction,
    output logic [XLEN-1:0] instr_pc,
    output logic            instr_valid,
    input  logic            instr_ready,
    output logic [1:0]      dbg_state
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam logic [XLEN-1:0] NOP = XLEN'(32'h0000_0013);

    // Handshakes: memory accepts a request when imem_req && imem_gnt; the single outstanding
    // request completes on imem_rvalid; the decoder takes the head when instr_valid && instr_ready.
    typedef enum logic [1:0] {
        ST_IDLE         = 2'd0,
        ST_REQ          = 2'd1,
        ST_WAIT         = 2'd2,
        ST_WAIT_DISCARD = 2'd3
    } fetch_state_e;

    fetch_state_e    state_q, state_d;
    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
    logic [XLEN-1:0] req_pc_q, req_pc_d;
    logic [XLEN-1:0] last_pc_q, last_pc_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [XLEN-1:0] fifo_instr_q [FIFO_DEPTH];
    logic [XLEN-1:0] fifo_instr_d [FIFO_DEPTH];
    logic [XLEN-1:0] fifo_pc_q    [FIFO_DEPTH];
    logic [XLEN-1:0] fifo_pc_d    [FIFO_DEPTH];

    logic outstanding;
    logic has_space;
    logic grant;
    logic resp;
    logic push;
    logic pop;

    always_comb begin
        outstanding = (state_q == ST_WAIT) || (state_q == ST_WAIT_DISCARD);
        has_space   = (count_q < CNT_W'(FIFO_DEPTH));
        imem_req    = !rst && !outstanding && !redirect_valid && has_space;
        imem_addr   = fetch_pc_q;
        grant       = imem_req && imem_gnt;
        resp        = imem_rvalid && outstanding;
        push        = resp && (state_q == ST_WAIT) && !redirect_valid;
        instr_valid = (count_q != '0);
        pop         = instr_valid && instr_ready && !redirect_valid;
        instruction = instr_valid ? fifo_instr_q[rd_ptr_q] : NOP;
        instr_pc    = instr_valid ? fifo_pc_q[rd_ptr_q] : last_pc_q;
        // The not-outstanding register state splits into REQ/IDLE depending on whether a request is possible.
        if (state_q == ST_REQ && !imem_req) begin
            dbg_state = ST_IDLE;
        end else begin
            dbg_state = state_q;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_REQ: begin
                if (grant) begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (imem_rvalid) begin
                    state_d = ST_REQ;
                end else if (redirect_valid) begin
                    state_d = ST_WAIT_DISCARD;
                end
            end
            ST_WAIT_DISCARD: begin
                if (imem_rvalid) begin
                    state_d = ST_REQ;
                end
            end
            default: state_d = ST_REQ;
        endcase
    end

    always_comb begin
        fetch_pc_d   = fetch_pc_q;
        req_pc_d     = req_pc_q;
        last_pc_d    = instr_pc;
        rd_ptr_d     = rd_ptr_q;
        wr_ptr_d     = wr_ptr_q;
        count_d      = count_q;
        fifo_instr_d = fifo_instr_q;
        fifo_pc_d    = fifo_pc_q;

        if (redirect_valid) begin
            fetch_pc_d = {redirect_target[XLEN-1:2], 2'b00};
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
            count_d    = '0;
        end else begin
            if (grant) begin
                fetch_pc_d = fetch_pc_q + XLEN'(4);
                req_pc_d   = fetch_pc_q;
            end
            if (push) begin
                fifo_instr_d[wr_ptr_q] = imem_rdata;
                fifo_pc_d[wr_ptr_q]    = req_pc_q;
                wr_ptr_d               = wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_REQ;
            fetch_pc_q <= RESET_PC;
            req_pc_q   <= '0;
            last_pc_q  <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_instr_q[i] <= '0;
                fifo_pc_q[i]    <= '0;
            end
        end else begin
            state_q      <= state_d;
            fetch_pc_q   <= fetch_pc_d;
            req_pc_q     <= req_pc_d;
            last_pc_q    <= last_pc_d;
            rd_ptr_q     <= rd_ptr_d;
            wr_ptr_q     <= wr_ptr_d;
            count_q      <= count_d;
            fifo_instr_q <= fifo_instr_d;
            fifo_pc_q    <= fifo_pc_d;
        end
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: a behavioural memory plus a program-order model of what the decoder
// must see (consecutive words from the last reset/redirect target), with directed and random phases.
module tb_instr_fetch_unit;

    localparam int          DEPTH    = 2;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] NOP      = 32'h0000_0013;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
    } entry_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt = 1'b0;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_target = '0;
    logic [31:0] instruction;
    logic [31:0] instr_pc;
    logic        instr_valid;
    logic        instr_ready = 1'b0;
    logic [1:0]  dbg_state;

    instr_fetch_unit #(
        .XLEN(32), .RESET_PC(RESET_PC), .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk(clk), .rst(rst),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .redirect_valid(redirect_valid), .redirect_target(redirect_target),
        .instruction(instruction), .instr_pc(instr_pc),
        .instr_valid(instr_valid), .instr_ready(instr_ready),
        .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    // reference model state
    entry_t      exp_q[$];
    logic        m_out, m_disc;
    logic [31:0] m_fetch, m_req_pc, m_stream, m_last_pc;
    // memory model state
    logic        mem_pend;
    int          mem_lat;
    logic [31:0] mem_addr;
    int          lat_min, lat_max, gnt_pct;
    // observation
    int          n_checks, n_pass;
    int          dut_grants;
    logic [31:0] gaddr_q[$];
    logic        last_grant;
    logic [31:0] last_grant_addr;

    function automatic logic [31:0] mem_word(input logic [31:0] addr);
        case (addr)
            32'h0000_0000: return 32'h0031_0233;
            32'h0000_0004: return 32'h0031_1333;
            32'h0000_0008: return 32'h0040_1263;
            default:       return {addr[15:0] ^ 16'hC3A5, addr[31:16] ^ 16'h1E0F};
        endcase
    endfunction

    function automatic logic [31:0] gaddr_at(input int i);
        if (i < gaddr_q.size()) return gaddr_q[i];
        return 32'hxxxx_xxxx;
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    endtask

    task automatic model_reset();
        exp_q.delete();
        m_out = 1'b0; m_disc = 1'b0;
        m_fetch = RESET_PC; m_stream = RESET_PC;
        m_last_pc = '0; m_req_pc = '0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2;
        rst = 1'b1; imem_gnt = 1'b0; imem_rvalid = 1'b0; redirect_valid = 1'b0;
        #1;
        check_eq("rst_req", imem_req, 1'b0);
        check_eq("rst_valid", instr_valid, 1'b0);
        check_eq("rst_instr", instruction, NOP);
        check_eq("rst_pc", instr_pc, 32'h0);
        model_reset();
        // an aborted request's response is still delivered by memory right after reset
        if (mem_pend) mem_lat = 0;
        gaddr_q.delete();
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic step(input logic redir, input logic [31:0] tgt, input logic ready);
        logic        exp_req, resp, gnt_now;
        logic [31:0] tgt_al;
        @(negedge clk);
        redirect_valid = redir; redirect_target = tgt; instr_ready = ready;
        if (mem_pend && mem_lat == 0) begin
            imem_rvalid = 1'b1; imem_rdata = mem_word(mem_addr); mem_pend = 1'b0;
        end else begin
            imem_rvalid = 1'b0; imem_rdata = $urandom;
            if (mem_pend) mem_lat--;
        end
        gnt_now  = ($urandom_range(0, 99) < gnt_pct);
        imem_gnt = gnt_now;
        #1;
        exp_req = !m_out && !redir && (exp_q.size() < DEPTH);
        check_eq("imem_req", imem_req, exp_req);
        if (exp_req) check_eq("imem_addr", imem_addr, m_fetch);
        check_eq("instr_valid", instr_valid, exp_q.size() != 0);
        if (exp_q.size() != 0) begin
            check_eq("head_instr", instruction, exp_q[0].instr);
            check_eq("head_pc", instr_pc, exp_q[0].pc);
        end else begin
            check_eq("empty_instr", instruction, NOP);
            check_eq("empty_pc", instr_pc, m_last_pc);
        end
        last_grant = 1'b0;
        if (imem_req && gnt_now) begin
            dut_grants++;
            gaddr_q.push_back(imem_addr);
            last_grant = 1'b1; last_grant_addr = imem_addr;
            mem_pend = 1'b1; mem_addr = imem_addr;
            mem_lat = int'($urandom_range(lat_min, lat_max)) - 1;
        end
        if (exp_q.size() != 0) m_last_pc = exp_q[0].pc;
        resp = imem_rvalid && m_out;
        if (redir) begin
            exp_q.delete();
            tgt_al = {tgt[31:2], 2'b00};
            m_fetch = tgt_al; m_stream = tgt_al;
            if (resp) begin
                m_out = 1'b0; m_disc = 1'b0;
            end else if (m_out) begin
                m_disc = 1'b1;
            end
        end else begin
            if (exp_q.size() != 0 && ready) begin
                void'(exp_q.pop_front());
                check_eq("stream_pc", instr_pc, m_stream);
                check_eq("stream_instr", instruction, mem_word(m_stream));
                m_stream = m_stream + 32'd4;
            end
            if (resp) begin
                m_out = 1'b0;
                if (m_disc) m_disc = 1'b0;
                else exp_q.push_back(entry_t'({imem_rdata, m_req_pc}));
            end
            if (exp_req && gnt_now) begin
                m_out = 1'b1; m_req_pc = m_fetch; m_fetch = m_fetch + 32'd4;
            end
        end
    endtask

    initial begin
        logic found;
        n_checks = 0; n_pass = 0; dut_grants = 0;
        mem_pend = 1'b0; mem_lat = 0; mem_addr = '0;
        lat_min = 1; lat_max = 1; gnt_pct = 100;
        last_grant = 1'b0; last_grant_addr = '0;
        model_reset();

        // sequential fetch from reset with 1-cycle memory
        do_reset();
        repeat (8) step(1'b0, 32'h0, 1'b1);
        check_eq("t1_addr0", gaddr_at(0), 32'h0);
        check_eq("t1_addr1", gaddr_at(1), 32'h4);

        // decoder stalled: only DEPTH words may be fetched
        do_reset();
        dut_grants = 0;
        repeat (10) step(1'b0, 32'h0, 1'b0);
        check_eq("stall_grants", dut_grants, DEPTH);
        check_eq("stall_addr1", gaddr_at(1), 32'h4);

        // resume, then redirect while 0x8 is outstanding; stale word returns two cycles later
        lat_min = 3; lat_max = 3;
        found = 1'b0;
        for (int i = 0; i < 12 && !found; i++) begin
            step(1'b0, 32'h0, 1'b1);
            if (last_grant && last_grant_addr == 32'h8) found = 1'b1;
        end
        check_eq("find_fetch8", found, 1'b1);
        gaddr_q.delete();
        step(1'b1, 32'h0000_0102, 1'b1);
        repeat (12) step(1'b0, 32'h0, 1'b1);
        check_eq("redir_addr", gaddr_at(0), 32'h100);

        // redirect coinciding with rvalid, then a second redirect
        lat_min = 1; lat_max = 1;
        found = 1'b0;
        for (int i = 0; i < 12 && !found; i++) begin
            step(1'b0, 32'h0, 1'b1);
            if (m_out && mem_pend && mem_lat == 0) found = 1'b1;
        end
        check_eq("find_rvalid", found, 1'b1);
        step(1'b1, 32'h0000_0180, 1'b1);
        gaddr_q.delete();
        step(1'b1, 32'h0000_0200, 1'b1);
        repeat (8) step(1'b0, 32'h0, 1'b1);
        check_eq("redir2_addr", gaddr_at(0), 32'h200);

        // async reset between grant and response
        lat_min = 3; lat_max = 3;
        found = 1'b0;
        for (int i = 0; i < 12 && !found; i++) begin
            step(1'b0, 32'h0, 1'b1);
            if (m_out) found = 1'b1;
        end
        check_eq("find_outst", found, 1'b1);
        do_reset();
        lat_min = 1; lat_max = 1;
        repeat (8) step(1'b0, 32'h0, 1'b1);
        check_eq("post_rst_addr", gaddr_at(0), RESET_PC);

        // PC wrap at the top of the address space
        gaddr_q.delete();
        step(1'b1, 32'hFFFF_FFFF, 1'b1);
        repeat (8) step(1'b0, 32'h0, 1'b1);
        check_eq("wrap_addr0", gaddr_at(0), 32'hFFFF_FFFC);
        check_eq("wrap_addr1", gaddr_at(1), 32'h0);

        // random traffic
        lat_min = 1; lat_max = 3; gnt_pct = 70;
        for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(0, 399) == 0) do_reset();
            step($urandom_range(0, 29) == 0, $urandom, $urandom_range(0, 3) != 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
